mem_stage_hs: RTL

- Memory-access pipeline stage between EXE and WB of the 5-stage MIPS core.
- Successor to the fixed single-cycle MEM stage. It waits for an SRAM-like `data_ok` response instead of assuming same-cycle read data.
- Performs full load extraction/extension (lb/lbu/lh/lhu/lw/lwl/lwr) and holds a response that arrives while WB is stalled.
- Supports a pipeline flush that drops in-flight responses, and exports a forwarding/stall bus to ID.

---
 rtl/mem_stage_hs.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_hs.sv
// Memory-access stage between EXE and WB: waits for the data SRAM response,
// extracts/extends load data, holds a response while WB stalls, and drops
// responses owed to instructions killed by a flush.
module mem_stage_hs #(
  parameter int ES_TO_MS_BUS_WD = 106,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39,
  parameter int CANCEL_CNT_W    = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic                       ms_flush,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LB   = 3'd1,
    MEM_LBU  = 3'd2,
    MEM_LH   = 3'd3,
    MEM_LHU  = 3'd4,
    MEM_LW   = 3'd5,
    MEM_LWL  = 3'd6,
    MEM_LWR  = 3'd7
  } mem_op_e;

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic                       r_buf_valid;
  logic [31:0]                r_buf_data;
  logic [CANCEL_CNT_W-1:0]    r_cancel_cnt;

  mem_op_e     w_mem_op;
  logic        w_mem_req;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_rt_value;
  logic [31:0] w_pc;
  logic [1:0]  w_off;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_final_result;
  logic        w_resp_live;
  logic        w_ready_go;
  logic        w_leave;
  logic        w_accept;
  logic        w_data_pending;
  logic        w_cancel_inc_ms;
  logic        w_cancel_inc_es;
  logic        w_cancel_dec;

  assign w_mem_op     = mem_op_e'(r_bus[105:103]);
  assign w_mem_req    = r_bus[102];
  assign w_gr_we      = r_bus[101];
  assign w_dest       = r_bus[100:96];
  assign w_alu_result = r_bus[95:64];
  assign w_rt_value   = r_bus[63:32];
  assign w_pc         = r_bus[31:0];
  assign w_off        = w_alu_result[1:0];

  // A response only belongs to the resident instruction once every response
  // owed to killed instructions has been discarded.
  assign w_resp_live  = data_sram_data_ok && (r_cancel_cnt == '0);
  assign w_cancel_dec = data_sram_data_ok && (r_cancel_cnt != '0);

  assign w_ready_go     = !w_mem_req || r_buf_valid || w_resp_live;
  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign w_leave        = ms_to_ws_valid && ws_allowin;
  assign w_accept       = es_to_ms_valid && ms_allowin && !ms_flush;
  assign w_data_pending = r_ms_valid && (w_mem_op != MEM_NONE) && !w_ready_go;

  // Requests issued but never answered for an instruction being killed.
  assign w_cancel_inc_ms = ms_flush && r_ms_valid && w_mem_req && !r_buf_valid && !w_resp_live;
  assign w_cancel_inc_es = ms_flush && es_to_ms_valid && ms_allowin && es_to_ms_bus[102];

  // Held data wins over the live bus so a stalled result stays stable.
  assign w_word = r_buf_valid ? r_buf_data : data_sram_rdata;
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  // Byte lane select and load alignment/extension.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    w_byte         = w_word[7:0];
    w_final_result = w_alu_result;
    case (w_off)
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    case (w_mem_op)
      MEM_LB:  w_final_result = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: w_final_result = {24'd0, w_byte};
      MEM_LH:  w_final_result = {{16{w_half[15]}}, w_half};
      MEM_LHU: w_final_result = {16'd0, w_half};
      MEM_LW:  w_final_result = w_word;
      MEM_LWL: begin
        case (w_off)
          2'd0:    w_final_result = {w_word[7:0],  w_rt_value[23:0]};
          2'd1:    w_final_result = {w_word[15:0], w_rt_value[15:0]};
          2'd2:    w_final_result = {w_word[23:0], w_rt_value[7:0]};
          default: w_final_result = w_word;
        endcase
      end
      MEM_LWR: begin
        case (w_off)
          2'd0:    w_final_result = w_word;
          2'd1:    w_final_result = {w_rt_value[31:24], w_word[31:8]};
          2'd2:    w_final_result = {w_rt_value[31:16], w_word[31:16]};
          default: w_final_result = {w_rt_value[31:8],  w_word[31:24]};
        endcase
      end
      default: w_final_result = w_alu_result;
    endcase
  end

  assign ms_to_ws_bus = ms_to_ws_valid ? {w_gr_we, w_dest, w_final_result, w_pc} : '0;
  assign ms_to_ds_bus = {r_ms_valid && w_gr_we, w_dest, w_final_result, w_data_pending};

  // Stage occupancy: flush kills, otherwise refill whenever the stage opens.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!resetn) begin
      r_ms_valid <= 1'b0;
    end else if (ms_flush) begin
      r_ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  // Instruction bus register, loaded only on an accepted, non-flushed handoff.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bus <= '0;
    end else if (w_accept) begin
      r_bus <= es_to_ms_bus;
    end
  end

  // Response buffer: captures the resident instruction's data while WB stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else if (ms_flush || w_leave) begin
      r_buf_valid <= 1'b0;
    end else if (w_resp_live && r_ms_valid && w_mem_req && !r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= data_sram_rdata;
    end
  end

  // Count of responses still owed to killed instructions (net of this cycle).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cancel_cnt <= '0;
    end else begin
      r_cancel_cnt <= r_cancel_cnt + CANCEL_CNT_W'(w_cancel_inc_ms)
                                   + CANCEL_CNT_W'(w_cancel_inc_es)
                                   - CANCEL_CNT_W'(w_cancel_dec);
    end
  end

endmodule
